// File: rtl/sha256_compress_iter.sv
// Iterative SHA-256 compression, ROUNDS_PER_CYCLE rounds per clock, on-the-fly message schedule and feed-forward add.
// Optional SHA256_DOUBLE_EN: a dbl request re-hashes the 256-bit digest in place before done.
module sha256_compress_iter #(
  parameter int ROUNDS_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         use_iv,
  input  logic         dbl,
  input  logic [511:0] block_in,
  input  logic [255:0] chain_in,
  output logic         busy,
  output logic         done,
  output logic [255:0] hash_out
);

  localparam int R     = ROUNDS_PER_CYCLE;
  localparam int ITERS = 64 / R;

  generate
    if (!(R == 1 || R == 2 || R == 4 || R == 8 || R == 16)) begin : g_bad_rounds
      $error("ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  localparam logic [255:0] IV_FLAT = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

`ifdef SHA256_DOUBLE_EN
  typedef enum logic [1:0] {IDLE, ROUND, FINAL, HASH2} state_t;
  logic dbl_q;
`else
  typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;
  logic unused_dbl;
  assign unused_dbl = dbl;
`endif

  state_t       state, state_nx;
  logic [5:0]   cnt;
  logic         fin_q;
  logic         accept;
  logic [31:0]  w     [16];
  logic [31:0]  v     [8];
  logic [31:0]  hv    [8];
  logic [31:0]  w_nx  [16];
  logic [31:0]  v_nx  [8];
  logic [255:0] chain_sel;
  logic [255:0] sum_flat;

  // fin_q marks the cycle between hash_out update and done; busy is still high there
  assign accept    = (state == IDLE) && start && !busy;
  assign chain_sel = use_iv ? IV_FLAT : chain_in;

  always_comb begin
    sum_flat = '0;
    for (int i = 0; i < 8; i++) sum_flat[255-32*i -: 32] = hv[i] + v[i];
  end

  // R chained rounds; x[16..] holds the schedule words generated this cycle
  always_comb begin
    logic [31:0] x [16+R];
    logic [31:0] s [8];
    logic [31:0] t1, t2;
    logic [5:0]  ti;
    for (int i = 0; i < 16; i++) x[i] = w[i];
    for (int k = 0; k < R; k++)
      x[16+k] = ssig1(x[14+k]) + x[9+k] + ssig0(x[1+k]) + x[k];
    for (int i = 0; i < 8; i++) s[i] = v[i];
    for (int j = 0; j < R; j++) begin
      ti   = 6'(int'(cnt) * R + j);
      t1   = s[7] + bsig1(s[4]) + ((s[4] & s[5]) ^ (~s[4] & s[6])) + K[ti] + x[j];
      t2   = bsig0(s[0]) + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
      s[7] = s[6];
      s[6] = s[5];
      s[5] = s[4];
      s[4] = s[3] + t1;
      s[3] = s[2];
      s[2] = s[1];
      s[1] = s[0];
      s[0] = t1 + t2;
    end
    for (int i = 0; i < 16; i++) w_nx[i] = x[i+R];
    for (int i = 0; i < 8; i++) v_nx[i] = s[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (accept) state_nx = ROUND;
      ROUND: if (cnt == 6'(ITERS - 1)) state_nx = FINAL;
`ifdef SHA256_DOUBLE_EN
      FINAL: state_nx = dbl_q ? HASH2 : IDLE;
      HASH2: state_nx = ROUND;
`else
      FINAL: state_nx = IDLE;
`endif
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      fin_q    <= 1'b0;
      cnt      <= '0;
      hash_out <= '0;
`ifdef SHA256_DOUBLE_EN
      dbl_q    <= 1'b0;
`endif
    end else begin
      done  <= fin_q;
      fin_q <= 1'b0;
      if (fin_q) busy <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          busy <= 1'b1;
          cnt  <= '0;
`ifdef SHA256_DOUBLE_EN
          dbl_q <= dbl;
`endif
        end
        ROUND: cnt <= cnt + 6'd1;
        FINAL: begin
`ifdef SHA256_DOUBLE_EN
          if (!dbl_q) begin
            hash_out <= sum_flat;
            fin_q    <= 1'b1;
          end
`else
          hash_out <= sum_flat;
          fin_q    <= 1'b1;
`endif
        end
`ifdef SHA256_DOUBLE_EN
        HASH2: begin
          cnt   <= '0;
          dbl_q <= 1'b0;
        end
`endif
        default: ;
      endcase
    end
  end

  // Datapath registers carry no reset; their contents only matter after a start
  always_ff @(posedge clk) begin
    case (state)
      IDLE: if (accept) begin
        for (int i = 0; i < 16; i++) w[i] <= block_in[511-32*i -: 32];
        for (int i = 0; i < 8; i++) begin
          hv[i] <= chain_sel[255-32*i -: 32];
          v[i]  <= chain_sel[255-32*i -: 32];
        end
      end
      ROUND: begin
        for (int i = 0; i < 16; i++) w[i] <= w_nx[i];
        for (int i = 0; i < 8; i++) v[i] <= v_nx[i];
      end
`ifdef SHA256_DOUBLE_EN
      FINAL: for (int i = 0; i < 8; i++) hv[i] <= hv[i] + v[i];
      HASH2: begin
        for (int i = 0; i < 8; i++) begin
          w[i]  <= hv[i];
          hv[i] <= IV_FLAT[255-32*i -: 32];
          v[i]  <= IV_FLAT[255-32*i -: 32];
        end
        w[8] <= 32'h80000000;
        for (int i = 9; i < 15; i++) w[i] <= 32'h0;
        w[15] <= 32'h00000100;
      end
`endif
      default: ;
    endcase
  end

endmodule
